// File: rtl/barrel_shift_pipe_if.sv
// Stream bundle for barrel_shift_pipe: operand side and result side.
// Optional out_carry exists only when BARREL_SHIFT_PIPE_CARRY_EN is defined.
//   in_valid/in_ready/in_data/in_amt/in_mode : operand stream
//   out_valid/out_ready/out_data[/out_carry] : result stream
//   master : producer + consumer side, slave : shifter side
interface barrel_shift_pipe_if #(
    parameter int N = 8
);
    localparam int AW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
`ifdef BARREL_SHIFT_PIPE_CARRY_EN
    logic          out_carry;
`endif

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
`ifdef BARREL_SHIFT_PIPE_CARRY_EN
        input  out_carry,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
`ifdef BARREL_SHIFT_PIPE_CARRY_EN
        output out_carry,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: LSL, LSR, ASR, ROL, ROR, pass-through (modes 5..7).
// Stage s shifts by 2^s when amount bit s is set; one register per stage.
// Ports: clk, reset (async, active-high), bus (barrel_shift_pipe_if.slave).
// Optional macro BARREL_SHIFT_PIPE_CARRY_EN adds out_carry (last bit out).
module barrel_shift_pipe #(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    barrel_shift_pipe_if.slave bus
);
    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROL = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;

    // sign is the operand MSB captured at acceptance, used for ASR fill
    typedef struct packed {
        logic          valid;
        logic          sign;
`ifdef BARREL_SHIFT_PIPE_CARRY_EN
        logic          carry;
`endif
        logic [2:0]    mode;
        logic [AW-1:0] amt;
        logic [N-1:0]  data;
    } stage_t;

    stage_t        st  [AW];
    stage_t        src [AW];
    stage_t        nxt [AW];
    stage_t        in_beat;
    logic [AW-1:0] rdy;

    function automatic logic [N-1:0] shf(
        input logic [N-1:0] d,
        input logic [2:0]   m,
        input logic         sg,
        input int           sh
    );
        logic [N-1:0] r;
        r = d;
        case (m)
            M_LSL:   r = d << sh;
            M_LSR:   r = d >> sh;
            M_ASR:   r = (d >> sh) | ({N{sg}} << (N - sh));
            M_ROL:   r = (d << sh) | (d >> (N - sh));
            M_ROR:   r = (d >> sh) | (d << (N - sh));
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef BARREL_SHIFT_PIPE_CARRY_EN
    // Partial shifts compose, so the last bit out of the final shifting
    // stage equals the last bit out of the whole shift.
    function automatic logic cout(
        input logic [N-1:0] d,
        input logic [N-1:0] r,
        input logic [2:0]   m,
        input int           sh
    );
        logic [N-1:0] t;
        logic         c;
        t = '0;
        c = 1'b0;
        case (m)
            M_LSL: begin
                t = d >> (N - sh);
                c = t[0];
            end
            M_LSR, M_ASR: begin
                t = d >> (sh - 1);
                c = t[0];
            end
            M_ROL:   c = r[0];
            M_ROR:   c = r[N-1];
            default: c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    function automatic stage_t step(input stage_t b, input int s);
        stage_t        r;
        logic [AW-1:0] a;
        int            sh;
        r  = b;
        a  = b.amt >> s;
        sh = 1 << s;
        if (a[0] && b.mode <= M_ROR) begin
            r.data = shf(b.data, b.mode, b.sign, sh);
`ifdef BARREL_SHIFT_PIPE_CARRY_EN
            r.carry = cout(b.data, r.data, b.mode, sh);
`endif
        end
        return r;
    endfunction

    always_comb begin
        in_beat       = '0;
        in_beat.valid = bus.in_valid;
        in_beat.sign  = bus.in_data[N-1];
        in_beat.mode  = bus.in_mode;
        in_beat.amt   = bus.in_amt;
        in_beat.data  = bus.in_data;
    end

    always_comb begin
        src[0] = in_beat;
        for (int s = 1; s < AW; s++) begin
            src[s] = st[s-1];
        end
        for (int s = 0; s < AW; s++) begin
            nxt[s] = step(src[s], s);
        end
    end

    // an empty stage is always ready, so bubbles collapse under a stall
    always_comb begin
        logic r;
        r   = bus.out_ready;
        rdy = '0;
        for (int s = AW - 1; s >= 0; s--) begin
            r      = !st[s].valid || r;
            rdy[s] = r;
        end
    end

    // payload loads only with a valid beat, so idle inputs never enter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < AW; s++) begin
                st[s] <= '0;
            end
        end else begin
            for (int s = 0; s < AW; s++) begin
                if (rdy[s]) begin
                    if (nxt[s].valid) begin
                        st[s] <= nxt[s];
                    end else begin
                        st[s].valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = st[AW-1].valid;
    assign bus.out_data  = st[AW-1].data;
`ifdef BARREL_SHIFT_PIPE_CARRY_EN
    assign bus.out_carry = st[AW-1].carry;
`endif
endmodule
